// File: rtl/ahb_lite_interconnect_pkg.sv
// Shared AHB-Lite types for the interconnect: transfer/size encodings,
// response codes and the default-slave state set.
package ahb_lite_interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BYTE     = 3'b000,
    HALFWORD = 3'b001,
    WORD     = 3'b010,
    DWORD    = 3'b011,
    LINE4    = 3'b100,
    LINE8    = 3'b101,
    LINE16   = 3'b110,
    LINE32   = 3'b111
  } hsize_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // NONSEQ and SEQ are the only transfer types that carry data.
  function automatic logic is_active(input htrans_e t);
    return t[1];
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped regions: two-cycle ERROR response FSM and a
// saturating count of unmapped transfers.
module ahb_default_slave
  import ahb_lite_interconnect_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 capture,
  output logic                 hready,
  output logic                 hresp,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  ds_state_e            state_r;
  logic                 hready_r;
  logic                 hresp_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Error response sequencer; outputs are registered alongside the state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r  <= DS_IDLE;
      hready_r <= 1'b1;
      hresp_r  <= HRESP_OKAY;
    end else begin
      case (state_r)
        DS_IDLE: begin
          if (capture) begin
            state_r  <= DS_ERR1;
            hready_r <= 1'b0;
            hresp_r  <= HRESP_ERROR;
          end else begin
            state_r  <= DS_IDLE;
            hready_r <= 1'b1;
            hresp_r  <= HRESP_OKAY;
          end
        end
        DS_ERR1: begin
          state_r  <= DS_ERR2;
          hready_r <= 1'b1;
          hresp_r  <= HRESP_ERROR;
        end
        DS_ERR2: begin
          if (capture) begin
            state_r  <= DS_ERR1;
            hready_r <= 1'b0;
            hresp_r  <= HRESP_ERROR;
          end else begin
            state_r  <= DS_IDLE;
            hready_r <= 1'b1;
            hresp_r  <= HRESP_OKAY;
          end
        end
        default: begin
          state_r  <= DS_IDLE;
          hready_r <= 1'b1;
          hresp_r  <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Unmapped-access counter, sticks at all-ones.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_cnt_r <= '0;
    end else if (capture && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
    end
  end

  assign hready  = hready_r;
  assign hresp   = hresp_r;
  assign err_cnt = err_cnt_r;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite decoder and response multiplexor with a built-in
// default slave answering ERROR for unmapped address regions.
module ahb_lite_interconnect
  import ahb_lite_interconnect_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [31:0]             HADDR,
  input  htrans_e                 HTRANS,
  input  hsize_e                  HSIZE,
  input  logic                    HWRITE,
  output logic [NUM_SLAVES-1:0]   HSEL_S,
  output logic                    HREADY_S,
  input  logic [NUM_SLAVES*32-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]   HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]   HRESP_S,
  output logic                    HREADY,
  output logic [31:0]             HRDATA,
  output logic                    HRESP,
  output logic [ERR_CNT_W-1:0]    ERR_CNT
);

  logic [3:0]            idx_s;
  logic                  unmapped_s;
  logic [NUM_SLAVES-1:0] hsel_s;
  logic                  dflt_sel_s;
  logic [NUM_SLAVES-1:0] owner_sel_r;
  logic                  owner_dflt_r;
  logic                  ds_hready_s;
  logic                  ds_hresp_s;
  logic                  hready_s;
  logic                  hresp_s;
  logic [31:0]           hrdata_s;
  logic                  unused_s;

  // Offset, size and direction reach the slaves on their own wires.
  assign unused_s = ^{HADDR[27:0], HSIZE, HWRITE};

  assign idx_s      = HADDR[31:28];
  assign unmapped_s = (idx_s >= 4'(NUM_SLAVES));
  assign dflt_sel_s = is_active(HTRANS) & unmapped_s;

  // One-hot region decode, gated by the transfer type.
  always_comb begin
    hsel_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hsel_s[i] = is_active(HTRANS) & (idx_s == 4'(i));
    end
  end

  // Data-phase owner, advancing only when the current data phase completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_sel_r  <= '0;
      owner_dflt_r <= 1'b0;
    end else if (hready_s) begin
      owner_sel_r  <= hsel_s;
      owner_dflt_r <= dflt_sel_s;
    end
  end

  ahb_default_slave #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_default_slave (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .capture (hready_s & dflt_sel_s),
    .hready  (ds_hready_s),
    .hresp   (ds_hresp_s),
    .err_cnt (ERR_CNT)
  );

  // Response mux; an empty owner vector yields zero read data.
  always_comb begin
    hrdata_s = 32'h0000_0000;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hrdata_s = hrdata_s | (HRDATA_S[32*i +: 32] & {32{owner_sel_r[i]}});
    end
    if (owner_dflt_r) begin
      hready_s = ds_hready_s;
      hresp_s  = ds_hresp_s;
    end else if (|owner_sel_r) begin
      hready_s = |(owner_sel_r & HREADYOUT_S);
      hresp_s  = |(owner_sel_r & HRESP_S);
    end else begin
      hready_s = 1'b1;
      hresp_s  = HRESP_OKAY;
    end
  end

  assign HSEL_S   = hsel_s;
  assign HREADY   = hready_s;
  assign HREADY_S = hready_s;
  assign HRESP    = hresp_s;
  assign HRDATA   = hrdata_s;

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench: the driver queues per-cycle expected responses, a monitor
// compares them against the bus on the falling edge.
module tb_ahb_lite_interconnect;
  import ahb_lite_interconnect_pkg::*;

  localparam int NS = 3;

  logic            hclk = 1'b0;
  logic            hresetn;
  logic [31:0]     haddr;
  htrans_e         htrans;
  hsize_e          hsize;
  logic            hwrite;
  logic [NS-1:0]   hsel_s;
  logic            hready_bc;
  logic [NS*32-1:0] hrdata_s;
  logic [NS-1:0]   hreadyout_s;
  logic [NS-1:0]   hresp_s;
  logic            hready;
  logic [31:0]     hrdata;
  logic            hresp;
  logic [7:0]      err_cnt;

  typedef struct {
    int          cyc;
    string       name;
    logic        rdy;
    logic        resp;
    logic [2:0]  sel;
    logic [7:0]  cnt;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 hclk = ~hclk;

  always @(posedge hclk) cyc <= cyc + 1;

  ahb_lite_interconnect #(
    .NUM_SLAVES (NS),
    .ERR_CNT_W  (8)
  ) dut (
    .HCLK        (hclk),
    .HRESETn     (hresetn),
    .HADDR       (haddr),
    .HTRANS      (htrans),
    .HSIZE       (hsize),
    .HWRITE      (hwrite),
    .HSEL_S      (hsel_s),
    .HREADY_S    (hready_bc),
    .HRDATA_S    (hrdata_s),
    .HREADYOUT_S (hreadyout_s),
    .HRESP_S     (hresp_s),
    .HREADY      (hready),
    .HRDATA      (hrdata),
    .HRESP       (hresp),
    .ERR_CNT     (err_cnt)
  );

  task automatic expect_now(input string name, input logic rdy, input logic resp,
                            input logic [2:0] sel, input logic [7:0] cnt,
                            input logic [31:0] data);
    exp_t e;
    e.cyc = cyc; e.name = name; e.rdy = rdy; e.resp = resp;
    e.sel = sel; e.cnt = cnt; e.data = data;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Monitor: pops every expectation due in the current cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge hclk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          failures++;
          $display("FAIL %s stale expectation for cyc=%0d seen at cyc=%0d", e.name, e.cyc, cyc);
        end else if ({hready, hready_bc, hresp, hsel_s, err_cnt, hrdata} !==
                     {e.rdy, e.rdy, e.resp, e.sel, e.cnt, e.data}) begin
          failures++;
          $display("FAIL %s cyc=%0d got rdy=%b/%b resp=%b sel=%b cnt=%0d data=%h want rdy=%b resp=%b sel=%b cnt=%0d data=%h",
                   e.name, cyc, hready, hready_bc, hresp, hsel_s, err_cnt, hrdata,
                   e.rdy, e.resp, e.sel, e.cnt, e.data);
        end
      end
    end
  end

  initial begin : driver
    int v;
    hresetn     = 1'b0;
    haddr       = 32'h2000_0000;
    htrans      = NONSEQ;
    hsize       = WORD;
    hwrite      = 1'b1;
    hreadyout_s = 3'b111;
    hresp_s     = 3'b000;
    hrdata_s    = {32'h2222_2222, 32'hFEDC_BA98, 32'h0000_AAAA};

    // Reset held with a live NONSEQ on the bus.
    for (int k = 0; k < 3; k++) begin
      step();
      expect_now("reset", 1'b1, 1'b0, 3'b100, 8'd0, 32'h0);
    end

    // Write to LED slave with 40 wait states.
    step();
    hresetn = 1'b1;
    hreadyout_s[2] = 1'b0;
    expect_now("led_addr", 1'b1, 1'b0, 3'b100, 8'd0, 32'h0);
    for (int k = 0; k < 40; k++) begin
      step();
      htrans = IDLE;
      expect_now("led_wait", 1'b0, 1'b0, 3'b000, 8'd0, 32'h2222_2222);
    end
    step();
    hreadyout_s[2] = 1'b1;
    expect_now("led_done", 1'b1, 1'b0, 3'b000, 8'd0, 32'h2222_2222);

    // Read mux from slave_1.
    step();
    haddr = 32'h1000_0004; htrans = NONSEQ; hwrite = 1'b0;
    expect_now("rd_addr", 1'b1, 1'b0, 3'b010, 8'd0, 32'h0);
    step();
    htrans = IDLE;
    expect_now("rd_data", 1'b1, 1'b0, 3'b000, 8'd0, 32'hFEDC_BA98);
    step();
    expect_now("rd_after_idle", 1'b1, 1'b0, 3'b000, 8'd0, 32'h0);

    // Single unmapped transfer, cancelled during the first error cycle.
    step();
    haddr = 32'h5000_0000; htrans = NONSEQ;
    expect_now("unm_addr", 1'b1, 1'b0, 3'b000, 8'd0, 32'h0);
    step();
    htrans = IDLE;
    expect_now("unm_err1", 1'b0, 1'b1, 3'b000, 8'd1, 32'h0);
    step();
    expect_now("unm_err2", 1'b1, 1'b1, 3'b000, 8'd1, 32'h0);
    step();
    expect_now("unm_done", 1'b1, 1'b0, 3'b000, 8'd1, 32'h0);

    // Back-to-back errors, then slave_0 taken from DS_ERR2 with no bubble.
    step();
    haddr = 32'hF000_0000; htrans = NONSEQ;
    expect_now("b2b_addr", 1'b1, 1'b0, 3'b000, 8'd1, 32'h0);
    step();
    expect_now("b2b_err1a", 1'b0, 1'b1, 3'b000, 8'd2, 32'h0);
    step();
    expect_now("b2b_err2a", 1'b1, 1'b1, 3'b000, 8'd2, 32'h0);
    step();
    haddr = 32'h0000_0010;
    expect_now("b2b_err1b", 1'b0, 1'b1, 3'b001, 8'd3, 32'h0);
    step();
    expect_now("b2b_err2b", 1'b1, 1'b1, 3'b001, 8'd3, 32'h0);
    step();
    htrans = IDLE;
    expect_now("b2b_s0", 1'b1, 1'b0, 3'b000, 8'd3, 32'h0000_AAAA);

    // 300 further unmapped transfers; counter must saturate at 255.
    step();
    haddr = 32'hF000_0000; htrans = NONSEQ;
    expect_now("sat_addr", 1'b1, 1'b0, 3'b000, 8'd3, 32'h0);
    for (int n = 1; n < 300; n++) begin
      step();
      v = 3 + n;
      if (v > 255) v = 255;
      expect_now("sat_err1", 1'b0, 1'b1, 3'b000, 8'(v), 32'h0);
      step();
    end
    step();
    htrans = IDLE;
    expect_now("sat_err1_last", 1'b0, 1'b1, 3'b000, 8'd255, 32'h0);
    step();
    expect_now("sat_err2_last", 1'b1, 1'b1, 3'b000, 8'd255, 32'h0);
    step();
    expect_now("sat_hold", 1'b1, 1'b0, 3'b000, 8'd255, 32'h0);

    // Reset while slave_2 stalls.
    step();
    haddr = 32'h2000_0000; htrans = NONSEQ; hwrite = 1'b1; hreadyout_s[2] = 1'b0;
    expect_now("rw_addr", 1'b1, 1'b0, 3'b100, 8'd255, 32'h0);
    step();
    htrans = IDLE;
    expect_now("rw_wait", 1'b0, 1'b0, 3'b000, 8'd255, 32'h2222_2222);
    step();
    hresetn = 1'b0;
    expect_now("rw_in_reset", 1'b1, 1'b0, 3'b000, 8'd0, 32'h0);
    step();
    hresetn = 1'b1; hreadyout_s = 3'b111;
    haddr = 32'h1000_0000; htrans = NONSEQ; hwrite = 1'b0;
    expect_now("rw_post_addr", 1'b1, 1'b0, 3'b010, 8'd0, 32'h0);
    step();
    htrans = IDLE;
    expect_now("rw_post_data", 1'b1, 1'b0, 3'b000, 8'd0, 32'hFEDC_BA98);

    // Reset in the middle of DS_ERR1.
    step();
    haddr = 32'h5000_0000; htrans = NONSEQ;
    expect_now("re_addr", 1'b1, 1'b0, 3'b000, 8'd0, 32'h0);
    step();
    htrans = IDLE;
    expect_now("re_err1", 1'b0, 1'b1, 3'b000, 8'd1, 32'h0);
    @(negedge hclk);
    #1;
    hresetn = 1'b0;
    step();
    expect_now("re_in_reset", 1'b1, 1'b0, 3'b000, 8'd0, 32'h0);
    step();
    hresetn = 1'b1;
    haddr = 32'h0000_0000; htrans = NONSEQ;
    expect_now("re_post_addr", 1'b1, 1'b0, 3'b001, 8'd0, 32'h0);
    step();
    htrans = IDLE;
    expect_now("re_post_data", 1'b1, 1'b0, 3'b000, 8'd0, 32'h0000_AAAA);
    step();
    expect_now("re_idle", 1'b1, 1'b0, 3'b000, 8'd0, 32'h0);

    step();
    step();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
